// File: rtl/hamming_encoder_tx_if.sv
// Handshake, fault-injection and serial-output signals of the Hamming(7,4) transmitter.
// The master side supplies nibbles and the slave side is the encoder.
interface hamming_encoder_tx_if;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] inject_pos;
    logic [6:0] codeword;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output in_data,
        output in_valid,
        output inject_pos,
        input  in_ready,
        input  codeword,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  inject_pos,
        output in_ready,
        output codeword,
        output tx,
        output busy,
        output done
    );
endinterface

// File: rtl/hamming_encoder_tx.sv
// Hamming(7,4) encoder with optional single-bit fault injection and a serial
// transmitter: one start bit (1) followed by cw[0]..cw[6], each BIT_CYCLES long.
module hamming_encoder_tx #(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    hamming_encoder_tx_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CYC = 8'(BIT_CYCLES - 1);

    state_t     state_reg;
    logic [2:0] bit_idx_reg;
    logic [7:0] cyc_cnt_reg;
    logic [6:0] codeword_reg;
    logic [6:0] shift_reg;
    logic       tx_reg;
    logic       busy_reg;
    logic       done_reg;
    logic       in_ready_reg;

    logic [3:0] d;
    logic [6:0] clean_cw;
    logic [6:0] flip_mask;
    logic [6:0] tx_cw;
    logic       accept;
    logic       bit_end;

    assign d = bus.in_data;

    // Positions 1,2,4 (1-based) carry parity; the data bits fill the rest.
    assign clean_cw = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3],
                       d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};

    // inject_pos == 7 matches no bit, so the clean codeword passes through.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_flip
            assign flip_mask[gi] = (bus.inject_pos == 3'(gi));
        end
    endgenerate

    assign tx_cw   = clean_cw ^ flip_mask;
    assign accept  = (state_reg == IDLE) && in_ready_reg && bus.in_valid;
    assign bit_end = (cyc_cnt_reg == LAST_CYC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            bit_idx_reg  <= 3'd0;
            cyc_cnt_reg  <= 8'd0;
            codeword_reg <= 7'h00;
            shift_reg    <= 7'h00;
            tx_reg       <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            in_ready_reg <= 1'b1;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        codeword_reg <= tx_cw;
                        shift_reg    <= tx_cw;
                        bit_idx_reg  <= 3'd0;
                        cyc_cnt_reg  <= 8'd0;
                        tx_reg       <= 1'b1;
                        busy_reg     <= 1'b1;
                        in_ready_reg <= 1'b0;
                        state_reg    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cyc_cnt_reg <= 8'd0;
                        bit_idx_reg <= 3'd0;
                        tx_reg      <= shift_reg[0];
                        shift_reg   <= {1'b0, shift_reg[6:1]};
                        state_reg   <= DATA;
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg + 8'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cyc_cnt_reg <= 8'd0;
                        if (bit_idx_reg == 3'd6) begin
                            // Done cycle doubles as the next accept opportunity.
                            bit_idx_reg  <= 3'd0;
                            tx_reg       <= 1'b0;
                            busy_reg     <= 1'b0;
                            done_reg     <= 1'b1;
                            in_ready_reg <= 1'b1;
                            state_reg    <= IDLE;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            tx_reg      <= shift_reg[0];
                            shift_reg   <= {1'b0, shift_reg[6:1]};
                        end
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    tx_reg       <= 1'b0;
                    busy_reg     <= 1'b0;
                    in_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_reg;
    assign bus.codeword = codeword_reg;
    assign bus.tx       = tx_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
endmodule

// File: tb/tb_hamming_encoder_tx.sv
// Directed bench for hamming_encoder_tx: one instance at BIT_CYCLES=1, one at 3.
module tb_hamming_encoder_tx;
    logic clk;
    logic rst_n;
    int   checks;
    int   passes;

    hamming_encoder_tx_if bus1 ();
    hamming_encoder_tx_if bus3 ();

    hamming_encoder_tx #(.BIT_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    hamming_encoder_tx #(.BIT_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    // Hand-computed codewords for nibbles 0..F.
    logic [6:0] cw_table [16];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (bus1.tx !== 1'b0 || bus1.busy !== 1'b0 || bus1.done !== 1'b0 ||
            bus1.in_ready !== 1'b1 || bus1.codeword !== 7'h00) begin
            $display("FAIL reset_bc1: tx=%b busy=%b done=%b rdy=%b cw=%h, want 0 0 0 1 00",
                     bus1.tx, bus1.busy, bus1.done, bus1.in_ready, bus1.codeword);
        end else passes++;
        checks++;
        if (bus3.tx !== 1'b0 || bus3.busy !== 1'b0 || bus3.done !== 1'b0 ||
            bus3.in_ready !== 1'b1 || bus3.codeword !== 7'h00) begin
            $display("FAIL reset_bc3: tx=%b busy=%b done=%b rdy=%b cw=%h, want 0 0 0 1 00",
                     bus3.tx, bus3.busy, bus3.done, bus3.in_ready, bus3.codeword);
        end else passes++;
        $display("reset: outputs checked on both instances");
    endtask

    // One BIT_CYCLES=1 frame; in_data/in_valid/inject_pos are disturbed while busy.
    task automatic run_frame1(input logic [3:0] dat, input logic [2:0] inj,
                              input logic [6:0] exp_cw, input string tag);
        logic [7:0] exp_tx;
        int n;
        exp_tx = {exp_cw, 1'b1};
        n = 0;
        while (bus1.in_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (bus1.in_ready !== 1'b1) $display("FAIL %s_ready: in_ready=%b want 1", tag, bus1.in_ready);
        else passes++;
        bus1.in_data    = dat;
        bus1.inject_pos = inj;
        bus1.in_valid   = 1'b1;
        step();
        checks++;
        if (bus1.codeword !== exp_cw)
            $display("FAIL %s_codeword: got %h want %h", tag, bus1.codeword, exp_cw);
        else passes++;
        checks++;
        if (bus1.busy !== 1'b1 || bus1.in_ready !== 1'b0)
            $display("FAIL %s_busy: busy=%b rdy=%b want 1 0", tag, bus1.busy, bus1.in_ready);
        else passes++;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (bus1.tx !== exp_tx[k] || bus1.done !== 1'b0)
                $display("FAIL %s_tx%0d: tx=%b done=%b want tx=%b done=0",
                         tag, k, bus1.tx, bus1.done, exp_tx[k]);
            else passes++;
            bus1.inject_pos = 3'd0;
            bus1.in_data    = ~dat;
            bus1.in_valid   = (k % 2 == 0);
            step();
        end
        checks++;
        if (bus1.done !== 1'b1 || bus1.tx !== 1'b0 || bus1.busy !== 1'b0 ||
            bus1.in_ready !== 1'b1 || bus1.codeword !== exp_cw)
            $display("FAIL %s_done: done=%b tx=%b busy=%b rdy=%b cw=%h want 1 0 0 1 %h",
                     tag, bus1.done, bus1.tx, bus1.busy, bus1.in_ready, bus1.codeword, exp_cw);
        else passes++;
        bus1.in_valid   = 1'b0;
        bus1.inject_pos = 3'd7;
        step();
        checks++;
        if (bus1.done !== 1'b0 || bus1.busy !== 1'b0 || bus1.tx !== 1'b0)
            $display("FAIL %s_after: done=%b busy=%b tx=%b want 0 0 0",
                     tag, bus1.done, bus1.busy, bus1.tx);
        else passes++;
        $display("frame %s: data=%h inject=%0d codeword=%h", tag, dat, inj, bus1.codeword);
    endtask

    task automatic test_basic();
        run_frame1(4'hB, 3'd7, 7'h55, "basic_b");
    endtask

    task automatic test_inject();
        run_frame1(4'hB, 3'd2, 7'h51, "inject2");
        run_frame1(4'h0, 3'd6, 7'h40, "inject6");
    endtask

    task automatic test_all_nibbles();
        for (int i = 0; i < 16; i++) begin
            run_frame1(4'(i), 3'd7, cw_table[i], $sformatf("nib%0h", i));
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] dat_list [3];
        logic [7:0] exp_tx;
        dat_list[0] = 4'hB;
        dat_list[1] = 4'h6;
        dat_list[2] = 4'hD;
        bus3.inject_pos = 3'd7;
        bus3.in_data    = dat_list[0];
        bus3.in_valid   = 1'b1;
        step();
        for (int f = 0; f < 3; f++) begin
            exp_tx = {cw_table[dat_list[f]], 1'b1};
            for (int c = 0; c < 24; c++) begin
                checks++;
                if (bus3.tx !== exp_tx[c / 3] || bus3.busy !== 1'b1 ||
                    bus3.in_ready !== 1'b0 || bus3.done !== 1'b0)
                    $display("FAIL b2b_f%0d_c%0d: tx=%b busy=%b rdy=%b done=%b want %b 1 0 0",
                             f, c, bus3.tx, bus3.busy, bus3.in_ready, bus3.done, exp_tx[c / 3]);
                else passes++;
                step();
            end
            checks++;
            if (bus3.done !== 1'b1 || bus3.in_ready !== 1'b1 || bus3.tx !== 1'b0 ||
                bus3.codeword !== cw_table[dat_list[f]])
                $display("FAIL b2b_done%0d: done=%b rdy=%b tx=%b cw=%h want 1 1 0 %h",
                         f, bus3.done, bus3.in_ready, bus3.tx, bus3.codeword, cw_table[dat_list[f]]);
            else passes++;
            $display("b2b frame %0d: data=%h codeword=%h", f, dat_list[f], bus3.codeword);
            if (f < 2) bus3.in_data = dat_list[f + 1];
            else       bus3.in_valid = 1'b0;
            step();
        end
        checks++;
        if (bus3.busy !== 1'b0 || bus3.done !== 1'b0)
            $display("FAIL b2b_stop: busy=%b done=%b want 0 0", bus3.busy, bus3.done);
        else passes++;
    endtask

    task automatic test_reset_mid_frame();
        bus1.in_data    = 4'h5;
        bus1.inject_pos = 3'd7;
        bus1.in_valid   = 1'b1;
        step();
        bus1.in_valid = 1'b0;
        repeat (5) step();
        checks++;
        if (bus1.busy !== 1'b1 || bus1.tx !== cw_table[5][4])
            $display("FAIL midrst_pre: busy=%b tx=%b want 1 %b", bus1.busy, bus1.tx, cw_table[5][4]);
        else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus1.tx !== 1'b0 || bus1.busy !== 1'b0 || bus1.done !== 1'b0 ||
            bus1.in_ready !== 1'b1 || bus1.codeword !== 7'h00)
            $display("FAIL midrst_async: tx=%b busy=%b done=%b rdy=%b cw=%h want 0 0 0 1 00",
                     bus1.tx, bus1.busy, bus1.done, bus1.in_ready, bus1.codeword);
        else passes++;
        bus1.in_valid = 1'b1;
        bus1.in_data  = 4'hF;
        step();
        checks++;
        if (bus1.busy !== 1'b0 || bus1.codeword !== 7'h00)
            $display("FAIL midrst_hold: busy=%b cw=%h want 0 00", bus1.busy, bus1.codeword);
        else passes++;
        bus1.in_valid = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (bus1.done !== 1'b0 || bus1.busy !== 1'b0)
                $display("FAIL midrst_quiet%0d: done=%b busy=%b want 0 0", k, bus1.done, bus1.busy);
            else passes++;
            step();
        end
        $display("reset mid-frame: aborted, restarting");
        run_frame1(4'h9, 3'd7, 7'h4C, "after_rst");
    endtask

    initial begin
        checks = 0;
        passes = 0;
        cw_table[0]  = 7'h00; cw_table[1]  = 7'h07; cw_table[2]  = 7'h19; cw_table[3]  = 7'h1E;
        cw_table[4]  = 7'h2A; cw_table[5]  = 7'h2D; cw_table[6]  = 7'h33; cw_table[7]  = 7'h34;
        cw_table[8]  = 7'h4B; cw_table[9]  = 7'h4C; cw_table[10] = 7'h52; cw_table[11] = 7'h55;
        cw_table[12] = 7'h61; cw_table[13] = 7'h66; cw_table[14] = 7'h78; cw_table[15] = 7'h7F;
        rst_n           = 1'b0;
        bus1.in_data    = 4'h0;
        bus1.in_valid   = 1'b0;
        bus1.inject_pos = 3'd7;
        bus3.in_data    = 4'h0;
        bus3.in_valid   = 1'b0;
        bus3.inject_pos = 3'd7;
        repeat (2) step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_basic();
        test_inject();
        test_all_nibbles();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/hamming_encoder_tx.md
HAMMING_ENCODER_TX -- requirements
Module: hamming_encoder_tx

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 1, meaning clock cycles per serial bit (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_data  input  4  nibble to encode, d0=in_data[0]..d3=in_data[3].
REQ-005 SHALL have port in_valid  input  1  in_data presented for transfer.
REQ-006 SHALL have port in_ready  output  1  block can accept a nibble this cycle.
REQ-007 SHALL have port inject_pos  input  3  codeword bit to invert (0..6); value 7 = no injection.
REQ-008 SHALL have port codeword  output  7  registered 7-bit codeword of the frame in flight.
REQ-009 SHALL have port tx  output  1  serial line; idle level 0.
REQ-010 SHALL have port busy  output  1  frame in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at end of frame.

Function
REQ-012 SHALL map data into codeword as cw[2]=d0, cw[4]=d1, cw[5]=d2, cw[6]=d3.
REQ-013 SHALL compute parity as cw[0]=d0^d1^d3, cw[1]=d0^d2^d3, cw[3]=d1^d2^d3.
REQ-014 SHALL, when inject_pos is 0..6 at accept, invert that one codeword bit before latching; inject_pos=7 latches the clean codeword.
REQ-015 SHALL sample inject_pos only on the accept cycle; later changes do not affect the frame.
REQ-016 SHALL implement FSM states IDLE, START, DATA.
REQ-017 SHALL drive in_ready=1 only in IDLE; an accept occurs on a rising edge with in_valid&&in_ready.
REQ-018 SHALL, on accept, latch codeword, set busy=1, and enter START; codeword holds until the next accept.
REQ-019 SHALL drive tx=1 (start bit) for BIT_CYCLES cycles in START, then enter DATA.
REQ-020 SHALL in DATA shift cw[0] first through cw[6] last, each bit held BIT_CYCLES cycles, using a 3-bit bit index and an 8-bit cycle counter.
REQ-021 SHALL, after the last cycle of cw[6], return to IDLE with tx=0, busy=0, in_ready=1, and done=1 for exactly that one cycle.
REQ-022 SHALL have a frame length of exactly 8*BIT_CYCLES cycles from the first start-bit cycle to the done cycle (exclusive).
REQ-023 SHALL allow back-to-back frames: an accept in the done cycle starts the next start bit on the following cycle, with no extra idle cycle.
REQ-024 SHALL ignore in_valid while busy; in_data is not required to be held after accept.
REQ-025 SHALL register all outputs (tx, busy, done, codeword, in_ready), with no combinational path from inputs to outputs.
REQ-026 SHALL, for BIT_CYCLES=1, send one bit per cycle with no counter stall.

Reset
REQ-027 SHALL, on rst_n=0, asynchronously force IDLE with tx=0, busy=0, done=0, in_ready=1, codeword=7'h00, and counters at 0.
REQ-028 SHALL, on reset asserted mid-frame, abort the frame immediately with no done pulse; the first accept after rst_n rises starts a fresh frame.
REQ-029 SHALL not accept on the rising edge where rst_n deasserts, if rst_n is still low at that edge.

Verification
REQ-030 SHALL cover: BIT_CYCLES=1, in_data=4'hB, inject_pos=7 -> codeword=7'h55, and tx sequence from cycle after accept is 1,1,0,1,0,1,0,1, then done pulse, then tx=0.
REQ-031 SHALL cover: in_data=4'h0 and then 4'hF -> codeword 7'h00 and 7'h7F respectively; all 16 nibbles, when checked, satisfy REQ-012/013.
REQ-032 SHALL cover: in_data=4'hB, inject_pos=2 -> codeword=7'h51, with the serial bit 2 sent as 0.
REQ-033 SHALL cover: BIT_CYCLES=3 with in_valid held high -> each bit lasts 3 cycles, done every 24 cycles, in_ready high only in done cycles, and no gap between frames.
REQ-034 SHALL cover: rst_n pulsed low during DATA bit 4 -> outputs go to reset values without a clock edge, no done pulse, and the next frame is correct.
REQ-035 SHALL cover: in_valid toggling and in_data changing while busy -> frame contents unchanged and no extra accept.
